pos_grant_decoder: RTL and testbench

- Decodes a 2-bit lowest-set-bit position, plus a zero flag, into a registered one-hot grant for one of four agents.
- The grant is held until the granted agent signals done, or until a timeout expires.
- Sits downstream of the 4-bit priority encoder in the request/grant path. Accepts one encoded request at a time over a valid/ready handshake.

---
 rtl/pos_grant_decoder.sv | 90 +++++++++
 tb/tb_pos_grant_decoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pos_grant_decoder.sv
// Turns an encoded lowest-set-bit position into a held one-hot grant for four agents.
// The grant is released by the owner's done strobe or force-released after TIMEOUT cycles.
module pos_grant_decoder #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_pos,
    input  logic       in_zero,
    input  logic [3:0] done,
    output logic [3:0] grant,
    output logic       grant_valid,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           state, state_next;
    logic [3:0]       grant_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             err_next;
    logic             done_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= 4'b0000;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            cnt         <= cnt_next;
            timeout_err <= err_next;
        end
    end

    // Only the current owner's done bit can end a grant.
    assign done_hit = |(done & grant);

    always_comb begin
        state_next = state;
        grant_next = grant;
        cnt_next   = cnt;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && !in_zero) begin
                    grant_next = 4'b0001 << in_pos;
                    cnt_next   = '0;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                // done takes precedence over a timeout landing on the same cycle
                if (done_hit) begin
                    grant_next = 4'b0000;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
                    grant_next = 4'b0000;
                    cnt_next   = '0;
                    state_next = IDLE;
                    err_next   = 1'b1;
                end
            end
            default: begin
                grant_next = 4'b0000;
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready    = (state == IDLE);
    assign busy        = (state == GRANT);
    assign grant_valid = |grant;

endmodule

// File: tb/tb_pos_grant_decoder.sv
// Directed self-checking bench for pos_grant_decoder with the default TIMEOUT of 15.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pos_grant_decoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_pos;
    logic       in_zero;
    logic [3:0] done;
    logic [3:0] grant;
    logic       grant_valid;
    logic       busy;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    pos_grant_decoder #(.TIMEOUT(15), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pos      (in_pos),
        .in_zero     (in_zero),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] p, input logic z, input logic [3:0] d);
        in_valid = v;
        in_pos   = p;
        in_zero  = z;
        done     = d;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int held;
        int seen_err;
        logic released;

        rst_n = 1'b0;
        applyStimulus(1'b0, 2'd0, 1'b0, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_grant", grant, 4'b0000);
        checkOutput("rst_gvalid", grant_valid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_terr", timeout_err, 1'b0);
        checkOutput("rst_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // basic grant on pos 2, released by its done
        applyStimulus(1'b1, 2'd2, 1'b0, 4'b0000);
        nextCycle();
        applyStimulus(1'b0, 2'd0, 1'b0, 4'b0100);
        checkOutput("t1_grant", grant, 4'b0100);
        checkOutput("t1_gvalid", grant_valid, 1'b1);
        checkOutput("t1_busy", busy, 1'b1);
        checkOutput("t1_ready", in_ready, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 2'd0, 1'b0, 4'b0000);
        checkOutput("t1_rel_grant", grant, 4'b0000);
        checkOutput("t1_rel_ready", in_ready, 1'b1);
        checkOutput("t1_rel_terr", timeout_err, 1'b0);

        // zero flag drops the request
        applyStimulus(1'b1, 2'd3, 1'b1, 4'b0000);
        nextCycle();
        checkOutput("t2_grant", grant, 4'b0000);
        checkOutput("t2_ready", in_ready, 1'b1);
        checkOutput("t2_busy", busy, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b0, 4'b1111);
        nextCycle();
        checkOutput("t2_idle_done_grant", grant, 4'b0000);
        applyStimulus(1'b0, 2'd0, 1'b0, 4'b0000);

        // timeout on pos 1: grant held exactly 15 cycles
        applyStimulus(1'b1, 2'd1, 1'b0, 4'b0000);
        nextCycle();
        applyStimulus(1'b0, 2'd3, 1'b0, 4'b0000);
        held = 0;
        seen_err = 0;
        released = 1'b0;
        for (int i = 0; i < 40 && !released; i++) begin
            if (grant == 4'b0010) begin
                held++;
                if (timeout_err) seen_err++;
                nextCycle();
            end else begin
                released = 1'b1;
            end
        end
        checkOutput("t3_released", released, 1'b1);
        checkOutput("t3_hold_cycles", held, 15);
        checkOutput("t3_err_during_grant", seen_err, 0);
        checkOutput("t3_grant_after", grant, 4'b0000);
        checkOutput("t3_terr_pulse", timeout_err, 1'b1);
        nextCycle();
        checkOutput("t3_terr_clear", timeout_err, 1'b0);

        // wrong-agent done is ignored
        applyStimulus(1'b1, 2'd0, 1'b0, 4'b0000);
        nextCycle();
        applyStimulus(1'b0, 2'd0, 1'b0, 4'b1110);
        checkOutput("t4_grant_c0", grant, 4'b0001);
        nextCycle();
        checkOutput("t4_grant_c1", grant, 4'b0001);
        nextCycle();
        checkOutput("t4_grant_c2", grant, 4'b0001);
        nextCycle();
        checkOutput("t4_grant_c3", grant, 4'b0001);
        applyStimulus(1'b0, 2'd0, 1'b0, 4'b0001);
        nextCycle();
        applyStimulus(1'b0, 2'd0, 1'b0, 4'b0000);
        checkOutput("t4_rel_grant", grant, 4'b0000);
        checkOutput("t4_rel_terr", timeout_err, 1'b0);

        // done on the timeout cycle wins
        applyStimulus(1'b1, 2'd3, 1'b0, 4'b0000);
        nextCycle();
        applyStimulus(1'b0, 2'd0, 1'b0, 4'b0000);
        for (int i = 1; i <= 14; i++) begin
            checkOutput("t5_hold", grant, 4'b1000);
            nextCycle();
        end
        checkOutput("t5_hold_last", grant, 4'b1000);
        applyStimulus(1'b0, 2'd0, 1'b0, 4'b1000);
        nextCycle();
        applyStimulus(1'b0, 2'd0, 1'b0, 4'b0000);
        checkOutput("t5_rel_grant", grant, 4'b0000);
        checkOutput("t5_rel_terr", timeout_err, 1'b0);
        checkOutput("t5_rel_ready", in_ready, 1'b1);
        nextCycle();
        checkOutput("t5_terr_after", timeout_err, 1'b0);

        // async reset mid-grant
        applyStimulus(1'b1, 2'd2, 1'b0, 4'b0000);
        nextCycle();
        applyStimulus(1'b0, 2'd0, 1'b0, 4'b0000);
        checkOutput("t6_grant_pre", grant, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_async_grant", grant, 4'b0000);
        checkOutput("t6_async_gvalid", grant_valid, 1'b0);
        checkOutput("t6_async_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
        checkOutput("t6_ready_after", in_ready, 1'b1);
        checkOutput("t6_grant_after", grant, 4'b0000);

        // back-to-back with in_valid held high
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 2'(k), 1'b0, 4'b0000);
            nextCycle();
            checkOutput("t7_grant", grant, 4'b0001 << k);
            checkOutput("t7_onehot", $onehot0(grant), 1'b1);
            checkOutput("t7_ready_busy", in_ready, 1'b0);
            applyStimulus(1'b1, 2'(3 - k), 1'b0, 4'b0001 << k);
            nextCycle();
            checkOutput("t7_idle_grant", grant, 4'b0000);
            checkOutput("t7_idle_ready", in_ready, 1'b1);
        end
        applyStimulus(1'b0, 2'd0, 1'b0, 4'b0000);
        nextCycle();
        checkOutput("t7_final_grant", grant, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
